dht_responder: RTL and testbench
================================

# dht_responder

Single-wire DHT11-style sensor responder that runs on the 1 MHz system tick. It watches the shared humidity data line for a host start pulse, then drives the response preamble and a 40-bit frame (humidity, temperature and checksum) using open-drain signalling. It is the sensor end of the humidity-reader protocol. It sits in the smart-home design as a sensor emulator for bench and loopback builds, wired onto the same pulled-up data net as the humidity reader.

## Interface
Parameters:
- T_START_MIN, 10000: minimum host low time (µs / cycles) that counts as a valid start.
- T_WAIT, 45: delay from start-pulse release to response; covers the host's 40 µs high plus its 1 µs trailing low.
- T_RESP, 80: length of each response-preamble half, low then released.
- T_BIT_LOW, 50: low slot before every data bit, and the trailing low after bit 0.
- T_ZERO, 26: released time that encodes a 0.
- T_ONE, 70: released time that encodes a 1.

Ports:
- clk1M  in  1: 1 MHz clock; 1 cycle = 1 µs.
- rst_n  in  1: asynchronous active-low reset.
- enable  in  1: when 0, the block never answers a start pulse.
- hum_int, hum_dec, tmp_int, tmp_dec  in  8 each: values to report.
- Data_H  inout  1: open-drain line; the block only drives 0 or z.
- busy  out  1: high from start detection until the frame ends.
- frame_done  out  1: one-cycle pulse when the line is released after the trailing low.

## Operation
- Data_H passes through a 2-flop synchronizer; all decisions use the synchronized value `ln`.
- drive_low is a register; Data_H = drive_low ? 0 : z.
- Snapshot: on entry to RESP_LOW, latch {hum_int, hum_dec, tmp_int, tmp_dec, csum} into a 40-bit shift register. csum = (hum_int + hum_dec + tmp_int + tmp_dec) mod 256, with the carry discarded. Frame bits go out MSB first.
- Input changes after the snapshot do not affect the frame in progress.
- States and transitions:
  - IDLE: when ln = 0 and enable = 1, clear cnt and go to START_LOW.
  - START_LOW: count while ln = 0; cnt saturates at 0xFFFF.
    - On ln = 1 with cnt ≥ T_START_MIN, go to WAIT.
    - On ln = 1 with cnt < T_START_MIN, go to IDLE.
  - WAIT: line ignored; after T_WAIT cycles go to RESP_LOW.
  - RESP_LOW: drive_low = 1 for T_RESP cycles, then RESP_HIGH.
  - RESP_HIGH: line released for T_RESP cycles, then BIT_LOW.
  - BIT_LOW: drive_low = 1 for T_BIT_LOW cycles, then BIT_HIGH.
  - BIT_HIGH: line released for T_ONE cycles if the current bit is 1, T_ZERO if 0. Then shift and decrement bitcnt; go to BIT_LOW if bits remain, else END_LOW.
  - END_LOW: drive_low = 1 for T_BIT_LOW cycles, then release, pulse frame_done, go to IDLE.
- From WAIT to END_LOW the line is not monitored, and a host start pulse is ignored.
- busy = 1 in every state except IDLE and START_LOW.
- enable falling mid-frame does not abort the frame; it only blocks new starts.

## Timing
- Reset values: drive_low = 0 (line released), busy = 0, frame_done = 0, state = IDLE, cnt = 0, bitcnt = 40.
- Reset is asynchronous; asserting it mid-frame releases the line in the same instant.
- Input latency: 2 cycles of synchronizer delay, plus 1 cycle to the state register.
- Each timed state lasts exactly its parameter value in cycles; drive_low changes on the cycle after the state changes.
- Frame length after WAIT: 2·T_RESP + 40·T_BIT_LOW + Σbit-high + T_BIT_LOW.
  - All-zero frame: 160 + 2000 + 1040 + 50 = 3250 cycles.
- The counter is 16 bits and saturates, so a held-low line never wraps into a false start.
- The host must release within the T_WAIT window. Contention on Data_H is not detected.

## Structure
- Package dht_pkg holds:
  - the state enum (IDLE, START_LOW, WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW);
  - the default timing constants;
  - the frame width constant 40.
- One sub-module, line_sync: a 2-flop synchronizer with async active-low reset to 1, matching the pulled-up idle level.
- A frame-assembly function (bytes to 40 bits plus checksum) lives in dht_pkg so the bench reuses it.

## Test plan
- Bytes 0x37/0x00/0x19/0x00, host drives low 18000 µs then high 40 µs:
  - RESP_LOW starts 45 cycles after release (+2 sync);
  - the decoded frame is 0x3700190050;
  - frame_done pulses once.
- Host low pulse of 500 µs: no response, busy stays 0, Data_H never driven.
- Bit timing for frame 0xFF00FF00FE:
  - every low slot is 50 cycles;
  - 1-bit highs are 70 cycles and 0-bit highs are 26 cycles;
  - trailing low is 50 cycles.
- Inputs change to 0x12/0x34/0x56/0x78 during bit 10: the current frame keeps its old snapshot; the next frame reports csum 0x14.
- rst_n asserted during BIT_LOW: Data_H goes to z immediately; after release the block returns to IDLE and answers the next valid start.
- enable = 0 with a valid start pulse: no response; enable cleared mid-frame: the frame still completes.

Source files
------------

// File: rtl/dht_pkg.sv
// Shared types, default timing and frame assembly for the DHT responder.
package dht_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_LOW,
        WAIT,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW
    } dht_state_t;

    localparam int DHT_T_START_MIN = 10000;
    localparam int DHT_T_WAIT      = 45;
    localparam int DHT_T_RESP      = 80;
    localparam int DHT_T_BIT_LOW   = 50;
    localparam int DHT_T_ZERO      = 26;
    localparam int DHT_T_ONE       = 70;
    localparam int FRAME_W         = 40;

    function automatic logic [FRAME_W-1:0] dht_frame(
        input logic [7:0] hi,
        input logic [7:0] hd,
        input logic [7:0] ti,
        input logic [7:0] td
    );
        logic [7:0] cs;
        cs = hi + hd + ti + td;
        return {hi, hd, ti, td, cs};
    endfunction

endpackage

// File: rtl/dht_if.sv
// Value/status bundle between the sensor model owner and the responder.
interface dht_if;
    logic       enable;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] tmp_int;
    logic [7:0] tmp_dec;
    logic       busy;
    logic       frame_done;

    modport master (
        output enable, hum_int, hum_dec, tmp_int, tmp_dec,
        input  busy, frame_done
    );

    modport slave (
        input  enable, hum_int, hum_dec, tmp_int, tmp_dec,
        output busy, frame_done
    );
endinterface

// File: rtl/dht_line_sync.sv
// Two-flop synchronizer; resets high to match the pulled-up idle line.
module line_sync (
    input  logic clk1M,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1;

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            q  <= 1'b1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/dht_responder.sv
// DHT11-style sensor end: detects a host start, sends preamble and 40-bit frame.
module dht_responder
    import dht_pkg::*;
#(
    parameter int T_START_MIN = DHT_T_START_MIN,
    parameter int T_WAIT      = DHT_T_WAIT,
    parameter int T_RESP      = DHT_T_RESP,
    parameter int T_BIT_LOW   = DHT_T_BIT_LOW,
    parameter int T_ZERO      = DHT_T_ZERO,
    parameter int T_ONE       = DHT_T_ONE
) (
    input  logic clk1M,
    input  logic rst_n,
    dht_if.slave bus,
    inout  wire  Data_H
);
    dht_state_t         state, state_d;
    logic               ln, last;
    logic               drive_low, drive_d;
    logic               done_q, done_d;
    logic [15:0]        cnt, tlen;
    logic [5:0]         bitcnt;
    logic [FRAME_W-1:0] shreg;

    line_sync u_sync (.clk1M(clk1M), .rst_n(rst_n), .d(Data_H), .q(ln));

    assign Data_H         = drive_low ? 1'b0 : 1'bz;
    assign bus.busy       = (state != IDLE) && (state != START_LOW);
    assign bus.frame_done = done_q;

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        tlen = 16'd1;
        case (state)
            WAIT:               tlen = 16'(T_WAIT);
            RESP_LOW, RESP_HIGH: tlen = 16'(T_RESP);
            BIT_LOW, END_LOW:   tlen = 16'(T_BIT_LOW);
            BIT_HIGH:           tlen = shreg[FRAME_W-1] ? 16'(T_ONE)
                                                        : 16'(T_ZERO);
            default:            tlen = 16'd1;
        endcase
    end

    assign last = (cnt == tlen - 16'd1);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:      if (!ln && bus.enable) state_d = START_LOW;
            START_LOW: if (ln) state_d = (cnt >= 16'(T_START_MIN)) ? WAIT : IDLE;
            WAIT:      if (last) state_d = RESP_LOW;
            RESP_LOW:  if (last) state_d = RESP_HIGH;
            RESP_HIGH: if (last) state_d = BIT_LOW;
            BIT_LOW:   if (last) state_d = BIT_HIGH;
            BIT_HIGH:  if (last) state_d = (bitcnt == 6'd1) ? END_LOW : BIT_LOW;
            END_LOW:   if (last) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // cnt restarts on every state change and saturates so a stuck line never wraps
    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            bitcnt <= 6'(FRAME_W);
            shreg  <= '0;
        end else begin
            if (state_d != state)  cnt <= '0;
            else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;

            if (state == WAIT && state_d == RESP_LOW) begin
                shreg  <= dht_frame(bus.hum_int, bus.hum_dec,
                                    bus.tmp_int, bus.tmp_dec);
                bitcnt <= 6'(FRAME_W);
            end else if (state == BIT_HIGH && last) begin
                shreg  <= {shreg[FRAME_W-2:0], 1'b0};
                bitcnt <= bitcnt - 6'd1;
            end
        end
    end

    // done fires on the same edge that releases the trailing low
    always_comb begin
        drive_d = (state == RESP_LOW) || (state == BIT_LOW) || (state == END_LOW);
        done_d  = (state == IDLE) && drive_low;
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            drive_low <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            drive_low <= drive_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_dht_responder.sv
// Host-side bench: drives start pulses, decodes the line, checks against a model.
module tb_dht_responder;
    localparam int T_SM  = 1000;
    localparam int TW    = 45;
    localparam int TR    = 80;
    localparam int TBL   = 50;
    localparam int T0    = 26;
    localparam int T1    = 70;
    localparam int LAT   = TW + 4;

    logic clk1M = 1'b0;
    logic rst_n = 1'b0;
    logic host_low = 1'b0;
    wire  Data_H;

    int n_chk = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    int busy_cyc = 0;
    int dut_low = 0;

    dht_if bus ();

    assign Data_H = host_low ? 1'b0 : 1'bz;
    pullup (Data_H);

    dht_responder #(.T_START_MIN(T_SM)) dut (
        .clk1M (clk1M),
        .rst_n (rst_n),
        .bus   (bus),
        .Data_H(Data_H)
    );

    always #5 clk1M = ~clk1M;

    always @(negedge clk1M) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (bus.busy === 1'b1) busy_cyc++;
        if (Data_H === 1'b0 && !host_low) dut_low++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] model_frame(input int hi, input int hd,
                                                input int ti, input int td);
        int s;
        s = (hi + hd + ti + td) % 256;
        return {8'(hi), 8'(hd), 8'(ti), 8'(td), 8'(s)};
    endfunction

    task automatic set_vals(input logic [31:0] v);
        bus.hum_int = v[31:24];
        bus.hum_dec = v[23:16];
        bus.tmp_int = v[15:8];
        bus.tmp_dec = v[7:0];
    endtask

    task automatic host_start(input int low_us);
        @(negedge clk1M);
        host_low = 1'b1;
        repeat (low_us) @(negedge clk1M);
        host_low = 1'b0;
        #1;
    endtask

    task automatic meas(input logic lvl, output int n);
        n = 0;
        while (Data_H === lvl && n < 400) begin
            @(negedge clk1M);
            n++;
        end
    endtask

    task automatic capture(input logic [39:0] exp, input int chg_bit,
                           input logic [31:0] chg_val, input int en_bit);
        int lat, rl, rh, lo, hi, tl, bad_lo, bad_hi, total, exp_len, fd0;
        logic [39:0] f;
        logic b;
        fd0 = fd_cnt;
        lat = 0;
        while (Data_H !== 1'b0 && lat < 200) begin
            @(negedge clk1M);
            lat++;
        end
        chk("resp_latency", 64'(lat), 64'(LAT));
        meas(1'b0, rl);
        meas(1'b1, rh);
        chk("resp_low", 64'(rl), 64'(TR));
        chk("resp_high", 64'(rh), 64'(TR));
        f = '0;
        bad_lo = 0;
        bad_hi = 0;
        total = rl + rh;
        exp_len = 2 * TR + TBL;
        for (int i = 0; i < 40; i++) begin
            if (i == chg_bit) set_vals(chg_val);
            if (i == en_bit) bus.enable = 1'b0;
            meas(1'b0, lo);
            meas(1'b1, hi);
            b = (hi > (T0 + T1) / 2);
            f = {f[38:0], b};
            if (lo != TBL) bad_lo++;
            if (hi != (exp[39-i] ? T1 : T0)) bad_hi++;
            total += lo + hi;
            exp_len += TBL + (exp[39-i] ? T1 : T0);
        end
        meas(1'b0, tl);
        total += tl;
        chk("frame", 64'(f), 64'(exp));
        chk("bit_low_bad", 64'(bad_lo), 64'd0);
        chk("bit_high_bad", 64'(bad_hi), 64'd0);
        chk("trail_low", 64'(tl), 64'(TBL));
        chk("frame_len", 64'(total), 64'(exp_len));
        repeat (3) @(negedge clk1M);
        chk("frame_done_cnt", 64'(fd_cnt - fd0), 64'd1);
        chk("busy_after", 64'(bus.busy), 64'd0);
    endtask

    task automatic no_response(input string tag, input int low_us);
        int d0, b0, f0;
        d0 = dut_low;
        b0 = busy_cyc;
        f0 = fd_cnt;
        host_start(low_us);
        repeat (300) @(negedge clk1M);
        chk({tag, "_drive"}, 64'(dut_low - d0), 64'd0);
        chk({tag, "_busy"}, 64'(busy_cyc - b0), 64'd0);
        chk({tag, "_done"}, 64'(fd_cnt - f0), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int n, w;
        bus.enable = 1'b1;
        set_vals(32'h0);
        repeat (3) @(negedge clk1M);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.frame_done), 64'd0);
        chk("rst_line", 64'(Data_H), 64'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk1M);

        set_vals(32'h37001900);
        host_start(1800);
        capture(40'h3700190050, -1, 32'h0, -1);

        no_response("short", 500);

        set_vals(32'hFF00FF00);
        host_start(1500);
        capture(40'hFF00FF00FE, -1, 32'h0, -1);

        set_vals(32'hA1B2C3D4);
        host_start(1500);
        capture(model_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4), 10, 32'h12345678, -1);
        host_start(1500);
        capture(40'h1234567814, -1, 32'h0, -1);

        host_start(1500);
        n = 0;
        while (Data_H !== 1'b0 && n < 200) begin
            @(negedge clk1M);
            n++;
        end
        meas(1'b0, w);
        meas(1'b1, w);
        for (int i = 0; i < 3; i++) begin
            meas(1'b0, w);
            meas(1'b1, w);
        end
        repeat (10) @(negedge clk1M);
        chk("pre_rst_low", 64'(Data_H), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_line", 64'(Data_H), 64'd1);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        #20 rst_n = 1'b1;
        repeat (5) @(negedge clk1M);
        v = $urandom;
        set_vals(v);
        host_start(1500);
        capture(model_frame(v[31:24], v[23:16], v[15:8], v[7:0]), -1, 32'h0, -1);

        bus.enable = 1'b0;
        no_response("disabled", 1500);
        bus.enable = 1'b1;

        v = $urandom;
        set_vals(v);
        host_start(1500);
        capture(model_frame(v[31:24], v[23:16], v[15:8], v[7:0]), -1, 32'h0, 20);
        bus.enable = 1'b1;

        for (int k = 0; k < 2; k++) begin
            v = $urandom;
            set_vals(v);
            host_start(int'($urandom_range(2500, 1100)));
            capture(model_frame(v[31:24], v[23:16], v[15:8], v[7:0]), -1, 32'h0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
